pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_if.sv | 32 +++
 rtl/pipeline_ctrl.sv | 118 +++++++++++
 tb/tb_pipeline_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// Hazard/event inputs and pipeline control outputs exchanged between the
// pipeline controller (master) and the datapath stages (slave).
interface pipeline_ctrl_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 load_use;
    logic                 bch_taken;
    logic                 dmem_busy;
    logic                 halt_req;
    logic                 resume;
    logic                 pc_en;
    logic                 stall_en;
    logic                 jmp_bch_en;
    logic                 ifid_en;
    logic                 ifid_flush;
    logic                 idex_flush;
    logic                 pipe_en;
    logic                 halted;
    logic [CNT_WIDTH-1:0] stall_cnt;

    modport master (
        input  load_use, bch_taken, dmem_busy, halt_req, resume,
        output pc_en, stall_en, jmp_bch_en, ifid_en, ifid_flush, idex_flush,
               pipe_en, halted, stall_cnt
    );

    modport slave (
        output load_use, bch_taken, dmem_busy, halt_req, resume,
        input  pc_en, stall_en, jmp_bch_en, ifid_en, ifid_flush, idex_flush,
               pipe_en, halted, stall_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline controller: boot hold, hazard stall/flush sequencing,
// debug halt/resume and a saturating stall-cycle counter.
//
// state | meaning
// BOOT  | PC held for BOOT_HOLD cycles after reset release
// RUN   | normal execution, hazards resolved by priority
// HALT  | core halted until resume
module pipeline_ctrl #(
    parameter int BOOT_HOLD = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    pipeline_ctrl_if.master  pif
);
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_INIT = 4'(BOOT_HOLD - 1);

    state_t               state_q, state_d;
    logic [3:0]           hold_q, hold_d;
    logic                 block_q, block_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic pc_en, stall_en, jmp_bch_en, ifid_en, ifid_flush, idex_flush;
    logic pipe_en, halted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            hold_q  <= HOLD_INIT;
            block_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            block_q <= block_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        block_d    = 1'b0;
        cnt_d      = cnt_q;
        pc_en      = 1'b0;
        stall_en   = 1'b0;
        jmp_bch_en = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        pipe_en    = 1'b0;
        halted     = 1'b0;

        unique case (state_q)
            BOOT: begin
                stall_en = 1'b1;
                if (hold_q == 4'd0) begin
                    state_d = RUN;
                end else begin
                    hold_d = hold_q - 4'd1;
                end
            end
            RUN: begin
                if (pif.dmem_busy) begin
                    // everything frozen; lower-priority events wait
                end else if (pif.halt_req) begin
                    stall_en = 1'b1;
                    state_d  = HALT;
                end else if (pif.bch_taken) begin
                    pc_en      = 1'b1;
                    ifid_en    = 1'b1;
                    pipe_en    = 1'b1;
                    jmp_bch_en = 1'b1;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (pif.load_use && !block_q) begin
                    idex_flush = 1'b1;
                    pipe_en    = 1'b1;
                    block_d    = 1'b1;
                end else begin
                    pc_en   = 1'b1;
                    ifid_en = 1'b1;
                    pipe_en = 1'b1;
                end
                if (!pc_en && (cnt_q != '1)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HALT: begin
                stall_en = 1'b1;
                halted   = 1'b1;
                if (pif.resume) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
                hold_d  = HOLD_INIT;
            end
        endcase
    end

    assign pif.pc_en      = pc_en;
    assign pif.stall_en   = stall_en;
    assign pif.jmp_bch_en = jmp_bch_en;
    assign pif.ifid_en    = ifid_en;
    assign pif.ifid_flush = ifid_flush;
    assign pif.idex_flush = idex_flush;
    assign pif.pipe_en    = pipe_en;
    assign pif.halted     = halted;
    assign pif.stall_cnt  = cnt_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed, table-driven bench for pipeline_ctrl (BOOT_HOLD=2, 5-bit counter).
module tb_pipeline_ctrl;
    localparam int CW = 5;

    // {pc_en, ifid_en, pipe_en, stall_en, jmp_bch_en, ifid_flush, idex_flush, halted}
    localparam logic [7:0] O_BOOT = 8'b0001_0000;
    localparam logic [7:0] O_RUN  = 8'b1110_0000;
    localparam logic [7:0] O_BUSY = 8'b0000_0000;
    localparam logic [7:0] O_HREQ = 8'b0001_0000;
    localparam logic [7:0] O_BCH  = 8'b1110_1110;
    localparam logic [7:0] O_LU   = 8'b0010_0010;
    localparam logic [7:0] O_HALT = 8'b0001_0001;

    // inputs packed as {load_use, bch_taken, dmem_busy, halt_req, resume}
    typedef struct {
        logic [4:0] in;
        logic [7:0] exp;
        int         cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    vec_t vecs[22];

    pipeline_ctrl_if #(.CNT_WIDTH(CW)) pif ();

    pipeline_ctrl #(.BOOT_HOLD(2), .CNT_WIDTH(CW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pif   (pif)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] outs();
        return {pif.pc_en, pif.ifid_en, pif.pipe_en, pif.stall_en,
                pif.jmp_bch_en, pif.ifid_flush, pif.idex_flush, pif.halted};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] v);
        {pif.load_use, pif.bch_taken, pif.dmem_busy, pif.halt_req, pif.resume} = v;
    endtask

    // inputs applied just after the edge, outputs checked at the falling edge
    task automatic step_chk(input string name, input logic [4:0] v,
                            input logic [7:0] e, input int c);
        drive(v);
        @(negedge clk);
        chk({name, " outs"}, int'(outs()), int'(e));
        chk({name, " cnt"}, int'(pif.stall_cnt), c);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{5'b00000, O_RUN,  0};
        vecs[1]  = '{5'b10000, O_LU,   0};
        vecs[2]  = '{5'b10000, O_RUN,  1};
        vecs[3]  = '{5'b10000, O_LU,   1};
        vecs[4]  = '{5'b00000, O_RUN,  2};
        vecs[5]  = '{5'b11000, O_BCH,  2};
        vecs[6]  = '{5'b10000, O_LU,   2};
        vecs[7]  = '{5'b00000, O_RUN,  3};
        vecs[8]  = '{5'b01100, O_BUSY, 3};
        vecs[9]  = '{5'b01100, O_BUSY, 4};
        vecs[10] = '{5'b01100, O_BUSY, 5};
        vecs[11] = '{5'b01100, O_BUSY, 6};
        vecs[12] = '{5'b01000, O_BCH,  7};
        vecs[13] = '{5'b00000, O_RUN,  7};
        vecs[14] = '{5'b10100, O_BUSY, 7};
        vecs[15] = '{5'b10000, O_LU,   8};
        vecs[16] = '{5'b00000, O_RUN,  9};
        vecs[17] = '{5'b01010, O_HREQ, 9};
        vecs[18] = '{5'b00000, O_HALT, 10};
        vecs[19] = '{5'b10110, O_HALT, 10};
        vecs[20] = '{5'b00001, O_HALT, 10};
        vecs[21] = '{5'b00000, O_RUN,  10};

        drive(5'b00000);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset outs", int'(outs()), int'(O_BOOT));
        chk("reset cnt", int'(pif.stall_cnt), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step_chk("boot1", 5'b00000, O_BOOT, 0);
        step_chk("boot2", 5'b00000, O_BOOT, 0);

        for (int i = 0; i < 22; i++) begin
            step_chk($sformatf("vec%0d", i), vecs[i].in, vecs[i].exp, vecs[i].cnt);
        end

        // asynchronous reset while halted
        step_chk("halt_req2", 5'b00010, O_HREQ, 10);
        step_chk("halted2", 5'b00000, O_HALT, 11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_in_halt outs", int'(outs()), int'(O_BOOT));
        chk("rst_in_halt cnt", int'(pif.stall_cnt), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step_chk("reboot1", 5'b00000, O_BOOT, 0);
        step_chk("reboot2", 5'b00000, O_BOOT, 0);
        step_chk("reboot_run", 5'b00000, O_RUN, 0);

        // counter saturation under a long memory stall
        for (int i = 0; i < 40; i++) begin
            step_chk($sformatf("sat%0d", i), 5'b00100, O_BUSY, (i < 31) ? i : 31);
        end
        @(negedge clk);
        chk("sat hold cnt", int'(pif.stall_cnt), 31);

        // asynchronous reset mid-stall
        rst_n = 1'b0;
        #1;
        chk("rst_in_stall outs", int'(outs()), int'(O_BOOT));
        chk("rst_in_stall cnt", int'(pif.stall_cnt), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step_chk("boot_after_stall1", 5'b00100, O_BOOT, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_in_boot outs", int'(outs()), int'(O_BOOT));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step_chk("boot3a", 5'b00000, O_BOOT, 0);
        step_chk("boot3b", 5'b00000, O_BOOT, 0);
        step_chk("boot3_run", 5'b00000, O_RUN, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
